// File: rtl/pong_score_pkg.sv
// Shared definitions for the pong scoring stage: FSM states, screen constants,
// glyph geometry and the 7-segment lookup.
package pong_score_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam logic [9:0] MID_X = 10'd320;

  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 28;

  // Segment pattern, bit 6 = a ... bit 0 = g; codes above 9 render blank.
  function automatic logic [6:0] seg7_lut(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'h7E;
      4'd1:    return 7'h30;
      4'd2:    return 7'h6D;
      4'd3:    return 7'h79;
      4'd4:    return 7'h33;
      4'd5:    return 7'h5B;
      4'd6:    return 7'h5F;
      4'd7:    return 7'h70;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/pong_score_seg7_glyph.sv
// One 16 x 28 seven-segment digit; px/py are coordinates relative to the box
// origin, so anything left of or above the box wraps to a large value and misses.
module seg7_glyph
  import pong_score_pkg::*;
#(
  parameter int SEG_W = 4
) (
  input  logic [3:0] digit,
  input  logic [9:0] px,
  input  logic [9:0] py,
  output logic       on
);

  localparam logic [9:0] BOX_W   = 10'(GLYPH_W);
  localparam logic [9:0] BOX_H   = 10'(GLYPH_H);
  localparam logic [9:0] THICK   = 10'(SEG_W);
  localparam logic [9:0] RIGHT_X = 10'(GLYPH_W - SEG_W);
  localparam logic [9:0] MID_Y   = 10'((GLYPH_H - SEG_W) / 2);
  localparam logic [9:0] HALF_Y  = 10'(GLYPH_H / 2);
  localparam logic [9:0] BOT_Y   = 10'(GLYPH_H - SEG_W);

  logic [6:0] segs;
  logic       in_box, left_col, right_col, upper, top_row, mid_row, bot_row;

  always_comb begin
    segs      = seg7_lut(digit);
    in_box    = (px < BOX_W) && (py < BOX_H);
    left_col  = px < THICK;
    right_col = px >= RIGHT_X;
    upper     = py < HALF_Y;
    top_row   = py < THICK;
    mid_row   = (py >= MID_Y) && (py < MID_Y + THICK);
    bot_row   = py >= BOT_Y;
    on = in_box & ((segs[6] & top_row)
                 | (segs[5] & right_col & upper)
                 | (segs[4] & right_col & ~upper)
                 | (segs[3] & bot_row)
                 | (segs[2] & left_col & ~upper)
                 | (segs[1] & left_col & upper)
                 | (segs[0] & mid_row));
  end

endmodule

// File: rtl/pong_score.sv
// Pong scoring and serve control: counts wall hits, sequences serve / play /
// point hold / game over, and overlays both scores as 7-segment digits.
module pong_score
  import pong_score_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int HOLD_FRAMES = 30,
  parameter int D1_X        = 280,
  parameter int D2_X        = 344,
  parameter int D_Y         = 16,
  parameter int SEG_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       wall_h,
  input  logic [9:0] ball_x,
  input  logic       p1_srv,
  input  logic       p2_srv,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] serve_side,
  output logic       play,
  output logic       point_beep,
  output logic       game_over,
  output logic       digit_en
);

  localparam logic [3:0] WIN4  = 4'(WIN_SCORE);
  localparam logic [7:0] HOLD8 = 8'(HOLD_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [1:0] side_q, side_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       wall_q, p1_q, p2_q;
  logic       wall_rise, p1_rise, p2_rise;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SERVE;
      score_p1_q  <= '0;
      score_p2_q  <= '0;
      side_q      <= 2'b01;
      frame_cnt_q <= '0;
      wall_q      <= 1'b0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_p1_q  <= score_p1_d;
      score_p2_q  <= score_p2_d;
      side_q      <= side_d;
      frame_cnt_q <= frame_cnt_d;
      wall_q      <= wall_h;
      p1_q        <= p1_srv;
      p2_q        <= p2_srv;
    end
  end

  assign wall_rise = wall_h & ~wall_q;
  assign p1_rise   = p1_srv & ~p1_q;
  assign p2_rise   = p2_srv & ~p2_q;

  always_comb begin
    // NOTE: every next-state variable is defaulted to its hold value first;
    // a path that leaves one unassigned would otherwise infer a latch.
    state_d     = state_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    side_d      = side_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      ST_SERVE: begin
        if ((p1_rise && side_q[1]) || (p2_rise && side_q[0])) begin
          state_d = ST_PLAY;
          side_d  = 2'b00;
        end
      end
      ST_PLAY: begin
        if (wall_rise) begin
          frame_cnt_d = '0;
          // The loser of the rally gets the next serve.
          if (ball_x < MID_X) begin
            score_p2_d = score_p2_q + 4'd1;
            side_d     = 2'b10;
            state_d    = (score_p2_d == WIN4) ? ST_OVER : ST_POINT;
          end else begin
            score_p1_d = score_p1_q + 4'd1;
            side_d     = 2'b01;
            state_d    = (score_p1_d == WIN4) ? ST_OVER : ST_POINT;
          end
        end
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (frame_cnt_q != 8'hFF) frame_cnt_d = frame_cnt_q + 8'd1;
          if (frame_cnt_d >= HOLD8) state_d = ST_SERVE;
        end
      end
      ST_OVER: begin
        if (p1_rise || p2_rise) begin
          score_p1_d  = '0;
          score_p2_d  = '0;
          side_d      = 2'b01;
          frame_cnt_d = '0;
          state_d     = ST_POINT;
        end
      end
      default: state_d = ST_SERVE;
    endcase
  end

  assign score_p1   = score_p1_q;
  assign score_p2   = score_p2_q;
  assign serve_side = side_q;
  assign play       = (state_q == ST_PLAY);
  assign point_beep = (state_q == ST_POINT);
  assign game_over  = (state_q == ST_OVER);

  logic on_p1, on_p2;

  seg7_glyph #(.SEG_W(SEG_W)) u_digit_p1 (
    .digit (score_p1_q),
    .px    (x - 10'(D1_X)),
    .py    (y - 10'(D_Y)),
    .on    (on_p1)
  );

  seg7_glyph #(.SEG_W(SEG_W)) u_digit_p2 (
    .digit (score_p2_q),
    .px    (x - 10'(D2_X)),
    .py    (y - 10'(D_Y)),
    .on    (on_p2)
  );

  assign digit_en = on_p1 | on_p2;

endmodule

// File: tb/tb_pong_score.sv
// Bench for pong_score: a rule-level game model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_pong_score;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0, wall_h = 1'b0, p1_srv = 1'b0, p2_srv = 1'b0;
  logic [9:0] ball_x = '0, x = '0, y = '0;
  logic [3:0] score_p1, score_p2;
  logic [1:0] serve_side;
  logic       play, point_beep, game_over, digit_en;

  int errors = 0;
  int checks = 0;

  pong_score dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .wall_h     (wall_h),
    .ball_x     (ball_x),
    .p1_srv     (p1_srv),
    .p2_srv     (p2_srv),
    .x          (x),
    .y          (y),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .serve_side (serve_side),
    .play       (play),
    .point_beep (point_beep),
    .game_over  (game_over),
    .digit_en   (digit_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  string m_mode;
  int    m_sc1, m_sc2, m_side, m_hold;
  bit    m_wall, m_b1, m_b2;
  string m_segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                         "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = "SERVE"; m_sc1 = 0; m_sc2 = 0; m_side = 1; m_hold = 0;
      m_wall = 0; m_b1 = 0; m_b2 = 0;
    end else begin
      bit r1, r2, rw;
      r1 = p1_srv && !m_b1;
      r2 = p2_srv && !m_b2;
      rw = wall_h && !m_wall;
      if (m_mode == "SERVE") begin
        if ((r1 && m_side == 2) || (r2 && m_side == 1)) begin
          m_mode = "PLAY"; m_side = 0;
        end
      end else if (m_mode == "PLAY") begin
        if (rw) begin
          if (ball_x < 320) begin m_sc2++; m_side = 2; end
          else              begin m_sc1++; m_side = 1; end
          if (m_sc1 == 9 || m_sc2 == 9) m_mode = "OVER";
          else begin m_mode = "POINT"; m_hold = 30; end
        end
      end else if (m_mode == "POINT") begin
        if (frame_tick) begin
          m_hold--;
          if (m_hold == 0) m_mode = "SERVE";
        end
      end else begin
        if (r1 || r2) begin
          m_sc1 = 0; m_sc2 = 0; m_side = 1; m_mode = "POINT"; m_hold = 30;
        end
      end
      m_wall = wall_h; m_b1 = p1_srv; m_b2 = p2_srv;
    end
  end

  function automatic bit glyph_lit(int d, int px, int py);
    string s;
    bit    lit = 0;
    if (d > 9 || px < 0 || px >= 16 || py < 0 || py >= 28) return 0;
    s = m_segs[d];
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": lit |= (py < 4);
        "g": lit |= (py >= 12 && py < 16);
        "d": lit |= (py >= 24);
        "b": lit |= (px >= 12 && py < 14);
        "c": lit |= (px >= 12 && py >= 14);
        "f": lit |= (px < 4 && py < 14);
        "e": lit |= (px < 4 && py >= 14);
        default: ;
      endcase
    end
    return lit;
  endfunction

  always @(negedge clk) begin
    check("score_p1", 16'(score_p1), 16'(m_sc1));
    check("score_p2", 16'(score_p2), 16'(m_sc2));
    check("serve_side", 16'(serve_side), 16'(m_side));
    check("play", 16'(play), 16'(m_mode == "PLAY"));
    check("point_beep", 16'(point_beep), 16'(m_mode == "POINT"));
    check("game_over", 16'(game_over), 16'(m_mode == "OVER"));
    check("digit_en", 16'(digit_en),
          16'(glyph_lit(m_sc1, int'(x) - 280, int'(y) - 16) |
              glyph_lit(m_sc2, int'(x) - 344, int'(y) - 16)));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
    end
  endtask

  task automatic serve(input bit p1);
    if (p1) p1_srv = 1'b1; else p2_srv = 1'b1;
    tick();
    p1_srv = 1'b0; p2_srv = 1'b0;
  endtask

  task automatic hit(input logic [9:0] bx);
    ball_x = bx; wall_h = 1'b1; tick();
    wall_h = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    // 1: reset values, wrong-side serve ignored, P2 serve starts play
    tick(); tick();
    check("rst score_p1", 16'(score_p1), 16'd0);
    check("rst score_p2", 16'(score_p2), 16'd0);
    check("rst serve_side", 16'(serve_side), 16'b01);
    check("rst play", 16'(play), 16'd0);
    rst = 1'b0; tick();
    serve(1'b1); tick();
    check("p1 serve ignored", 16'(play), 16'd0);
    serve(1'b0);
    check("p2 serve play", 16'(play), 16'd1);
    check("serve_side cleared", 16'(serve_side), 16'b00);
    tick();

    // 2: left-side hit scores for P2, hold, then only P1 may serve
    ball_x = 10'd10; wall_h = 1'b1; tick();
    check("p2 scored", 16'(score_p2), 16'd1);
    check("beep in point", 16'(point_beep), 16'd1);
    check("loser p1 serves", 16'(serve_side), 16'b10);
    wall_h = 1'b0; tick();
    hold(29);
    check("still holding at 29", 16'(point_beep), 16'd1);
    hold(1);
    check("serve after 30", 16'(point_beep), 16'd0);
    serve(1'b0); tick();
    check("p2 serve ignored", 16'(play), 16'd0);
    serve(1'b1);
    check("p1 serve play", 16'(play), 16'd1);
    tick();

    // 3: wall held high across 5 frames scores exactly once
    ball_x = 10'd630; wall_h = 1'b1; tick();
    hold(5);
    check("single point", 16'(score_p1), 16'd1);
    wall_h = 1'b0;
    hold(25);
    check("serve after held wall", 16'(point_beep), 16'd0);
    x = 10'd288; y = 10'd30; tick();
    check("digit 1 no g", 16'(digit_en), 16'd0);
    x = '0; y = '0;

    // 4: P1 runs up to the win, game over freezes, restart
    for (int k = 2; k <= 9; k++) begin
      serve(1'b0);
      hit(10'd630);
      if (k == 8) begin
        for (int xx = 276; xx < 300; xx += 3)
          for (int yy = 14; yy < 46; yy += 4) begin
            x = 10'(xx); y = 10'(yy); tick();
          end
        x = 10'd282; y = 10'd17; tick();
        check("digit 8 seg a", 16'(digit_en), 16'd1);
        x = 10'd288; y = 10'd30; tick();
        check("digit 8 seg g", 16'(digit_en), 16'd1);
        x = '0; y = '0;
      end
      if (k < 9) hold(30);
    end
    check("win p1", 16'(score_p1), 16'd9);
    check("win p2", 16'(score_p2), 16'd1);
    check("game over", 16'(game_over), 16'd1);
    hit(10'd630);
    hold(5);
    check("frozen p1", 16'(score_p1), 16'd9);
    check("still over", 16'(game_over), 16'd1);
    serve(1'b1);
    check("restart p1", 16'(score_p1), 16'd0);
    check("restart p2", 16'(score_p2), 16'd0);
    check("restart beep", 16'(point_beep), 16'd1);
    check("restart side", 16'(serve_side), 16'b01);
    tick();
    hold(30);
    check("restart served", 16'(point_beep), 16'd0);
    check("restart over cleared", 16'(game_over), 16'd0);

    // 5: asynchronous reset in the middle of a point hold
    serve(1'b0);
    hit(10'd10);
    hold(15);
    check("mid-hold beep", 16'(point_beep), 16'd1);
    rst = 1'b1;
    #1;
    check("async rst score_p2", 16'(score_p2), 16'd0);
    check("async rst side", 16'(serve_side), 16'b01);
    check("async rst beep", 16'(point_beep), 16'd0);
    check("async rst over", 16'(game_over), 16'd0);
    check("async rst play", 16'(play), 16'd0);
    tick();
    rst = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
